lut_result_writer: RTL and testbench
====================================

LUT_RESULT_WRITER -- requirements
Module: lut_result_writer

Interface
REQ-001 Parameters: DATA_W 32 sample width; AXI_ADDR_W 32 bus address width; AXI_DATA_W 32 bus data width (SHALL equal DATA_W); LEN_W 8 burst length width; FIFO_W 4 log2 FIFO depth (16 entries).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low (asserted at 0).
REQ-004 run  in  1  one-cycle start pulse; running  in  1  accelerator-active level.
REQ-005 done  out  1  high when idle or finished; overflow  out  1  sticky sample-dropped flag.
REQ-006 in0  in  DATA_W  sample stream, typically the out0 of the upstream lookup-table read stage.
REQ-007 Config inputs: ext_addr AXI_ADDR_W base byte address; count 32 samples to write; length LEN_W beats per burst; delay0 32 cycles from run to first sample; disabled 1.
REQ-008 Databus: databus_valid_0 out 1; databus_ready_0 in 1; databus_addr_0 out AXI_ADDR_W; databus_wdata_0 out AXI_DATA_W; databus_wstrb_0 out AXI_DATA_W/8; databus_len_0 out LEN_W; databus_last_0 in 1; databus_rdata_0 in AXI_DATA_W (ignored).

Function
REQ-009 run with disabled=0 SHALL flush FIFO, clear overflow, load delay counter from delay0, set done=0, enter DELAY; run with disabled=1 SHALL be ignored (done stays 1).
REQ-010 Capture: in0 SHALL be sampled in the cycle where the delay counter reaches 0 and on every following cycle until count samples are sampled; delay0=0 samples in the cycle after run.
REQ-011 Each sampled word SHALL be pushed into the FIFO; if full and no pop that cycle, the word SHALL be dropped, still counted, and overflow set to 1.
REQ-012 Push and pop in the same cycle SHALL leave occupancy unchanged and is legal when full.
REQ-013 Write FSM states: IDLE, DELAY, WAIT, BURST, FINISH.
REQ-014 WAIT: beats = min(max(length,1), remaining); BURST SHALL be entered when FIFO occupancy >= beats or all samples are captured (then beats = remaining minus dropped words, zero beats skips to FINISH).
REQ-015 BURST: databus_valid_0=1, databus_addr_0 = current address, databus_len_0 = beats, databus_wstrb_0 all ones, databus_wdata_0 = FIFO head (show-ahead, no extra latency).
REQ-016 Each cycle with valid&&ready SHALL pop one FIFO word; address, length and data SHALL stay stable while valid=1 and ready=0.
REQ-017 Burst SHALL end on valid&&ready&&databus_last_0; current address += beats*(AXI_DATA_W/8) (wraps modulo 2^AXI_ADDR_W); remaining -= beats; next state WAIT if remaining>0 else FINISH.
REQ-018 FINISH SHALL set done=1 next cycle and return to IDLE; count=0 SHALL go DELAY->FINISH with no bus traffic.
REQ-019 run during an active operation SHALL abort it and restart per REQ-009; valid SHALL drop in that cycle even mid-burst.
REQ-020 databus_valid_0 SHALL be 0 outside BURST.

Reset
REQ-021 During reset: done=1, overflow=0, databus_valid_0=0, databus_addr_0=0, databus_len_0=0, FIFO empty, counters 0, state IDLE.
REQ-022 Reset assertion mid-burst SHALL drop databus_valid_0 asynchronously.

Structure
REQ-023 FSM state encodings and the beats-to-bytes shift constant SHALL live in a shared package.
REQ-024 The FIFO SHALL be one sub-module, result_fifo (show-ahead, full/empty/occupancy outputs).

Verification
REQ-025 count=8, length=4, delay0=3, ext_addr=0x1000, ready=1 -> bursts at 0x1000 and 0x1010, len=4 each, data order preserved, done=1 after second last.
REQ-026 count=10, length=4 -> bursts len 4,4,2 at 0x0, 0x10, 0x20.
REQ-027 ready toggling 1/0 every cycle -> wdata/addr stable while stalled, no word lost or duplicated.
REQ-028 ready=0 for 40 cycles, count=32 -> overflow=1, 16 words written, done=1 eventually.
REQ-029 disabled=1 with run -> no valid, done stays 1; count=0 -> done returns to 1 with no bus traffic.
REQ-030 rst=0 mid-burst -> valid=0 immediately, done=1; subsequent run completes normally.

Source files
------------

// File: rtl/lut_result_writer_pkg.sv
// Shared FSM encoding and bus geometry constants for the LUT result writer.
package lut_result_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELAY,
    ST_WAIT,
    ST_BURST,
    ST_FINISH
  } state_t;

  // log2 of bytes per 32-bit bus beat
  localparam int BEAT_SHIFT = 2;

endpackage

// File: rtl/lut_result_writer_result_fifo.sv
// Show-ahead sample FIFO: head is valid the cycle after a push into an empty FIFO.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module result_fifo #(
  parameter int W  = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   occupancy
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign empty   = (occupancy == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      occupancy <= occupancy + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/lut_result_writer.sv
// Captures count samples of in0 after a programmable delay and writes them out as bursts.
// Bursts start once enough words are buffered; a stalled bus fills the FIFO, then samples drop.
module lut_result_writer
  import lut_result_writer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    run,
  input  logic                    running,
  output logic                    done,
  output logic                    overflow,
  input  logic [DATA_W-1:0]       in0,
  input  logic [AXI_ADDR_W-1:0]   ext_addr,
  input  logic [31:0]             count,
  input  logic [LEN_W-1:0]        length,
  input  logic [31:0]             delay0,
  input  logic                    disabled,
  output logic                    databus_valid_0,
  input  logic                    databus_ready_0,
  output logic [AXI_ADDR_W-1:0]   databus_addr_0,
  output logic [AXI_DATA_W-1:0]   databus_wdata_0,
  output logic [AXI_DATA_W/8-1:0] databus_wstrb_0,
  output logic [LEN_W-1:0]        databus_len_0,
  input  logic                    databus_last_0,
  input  logic [AXI_DATA_W-1:0]   databus_rdata_0
);

  state_t                  state;
  logic [31:0]             delay_cnt;
  logic [31:0]             cap_cnt;
  logic [31:0]             cnt_q;
  logic [31:0]             remaining;
  logic [31:0]             dropped;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        beats;
  logic [AXI_ADDR_W-1:0]   addr;
  logic [31:0]             want;
  logic [31:0]             chunk;
  logic [31:0]             fill;
  logic                    start;
  logic                    sample;
  logic                    pop;
  logic                    burst_end;
  logic                    full;
  logic                    empty;
  logic [FIFO_W:0]         occ;
  logic [DATA_W-1:0]       head;
  logic                    unused_pins;

  assign unused_pins = ^{databus_rdata_0, running, empty};

  // A restart pulls valid down combinationally so no beat leaks from the aborted burst.
  assign start           = run && !disabled;
  assign databus_valid_0 = (state == ST_BURST) && !start;
  assign databus_addr_0  = addr;
  assign databus_len_0   = beats;
  assign databus_wdata_0 = head;
  assign databus_wstrb_0 = '1;

  assign pop       = databus_valid_0 && databus_ready_0;
  assign burst_end = pop && databus_last_0;
  assign sample    = (state inside {ST_DELAY, ST_WAIT, ST_BURST}) && (delay_cnt == 0)
                     && (cap_cnt != cnt_q) && !start;

  // Once capture is complete, the FIFO holds exactly remaining - dropped words.
  always_comb begin
    want  = (len_q == '0) ? 32'd1 : 32'(len_q);
    chunk = (remaining < want) ? remaining : want;
    fill  = remaining - dropped;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      done      <= 1'b1;
      overflow  <= 1'b0;
      delay_cnt <= '0;
      cap_cnt   <= '0;
      cnt_q     <= '0;
      remaining <= '0;
      dropped   <= '0;
      len_q     <= '0;
      beats     <= '0;
      addr      <= '0;
    end else if (start) begin
      state     <= ST_DELAY;
      done      <= 1'b0;
      overflow  <= 1'b0;
      delay_cnt <= delay0;
      cap_cnt   <= '0;
      cnt_q     <= count;
      remaining <= count;
      dropped   <= '0;
      len_q     <= length;
      addr      <= ext_addr;
    end else begin
      if (delay_cnt != 0) delay_cnt <= delay_cnt - 1;
      if (sample) begin
        cap_cnt <= cap_cnt + 1;
        if (full && !pop) begin
          dropped  <= dropped + 1;
          overflow <= 1'b1;
        end
      end
      case (state)
        ST_DELAY: if (delay_cnt == 0) state <= (cnt_q == 0) ? ST_FINISH : ST_WAIT;
        ST_WAIT: begin
          if (32'(occ) >= chunk) begin
            beats <= chunk[LEN_W-1:0];
            state <= ST_BURST;
          end else if (cap_cnt == cnt_q) begin
            if (fill == 0) begin
              state <= ST_FINISH;
            end else begin
              beats <= fill[LEN_W-1:0];
              state <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          if (burst_end) begin
            addr      <= addr + (AXI_ADDR_W'(beats) << BEAT_SHIFT);
            remaining <= remaining - 32'(beats);
            state     <= (remaining == 32'(beats)) ? ST_FINISH : ST_WAIT;
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  result_fifo #(
    .W  (DATA_W),
    .AW (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (start),
    .push      (sample),
    .data      (in0),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_lut_result_writer.sv
// Directed + randomized bench for lut_result_writer with a bus-slave model and a burst/data reference.
module tb_lut_result_writer;

  logic        clk, rst, run, running, done, overflow, disabled;
  logic [31:0] in0, ext_addr, count, delay0;
  logic [7:0]  length;
  logic        databus_valid_0, databus_ready_0, databus_last_0;
  logic [31:0] databus_addr_0, databus_wdata_0, databus_rdata_0;
  logic [3:0]  databus_wstrb_0;
  logic [7:0]  databus_len_0;

  int total, bad, cyc, mode, stall_left, valid_cnt, r;
  bit chk_stall, stalled_prev;
  logic [31:0] prev_addr, prev_wdata;
  logic [7:0]  prev_len, beat_cnt;
  logic [31:0] in0_hist [int];
  logic [31:0] data_q[$];
  logic [31:0] baddr_q[$];
  logic [7:0]  blen_q[$];

  lut_result_writer dut (
    .clk(clk), .rst(rst), .run(run), .running(running), .done(done), .overflow(overflow),
    .in0(in0), .ext_addr(ext_addr), .count(count), .length(length), .delay0(delay0),
    .disabled(disabled), .databus_valid_0(databus_valid_0), .databus_ready_0(databus_ready_0),
    .databus_addr_0(databus_addr_0), .databus_wdata_0(databus_wdata_0),
    .databus_wstrb_0(databus_wstrb_0), .databus_len_0(databus_len_0),
    .databus_last_0(databus_last_0), .databus_rdata_0(databus_rdata_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus slave: asserts last on the len-th accepted beat of each burst.
  assign databus_last_0 = databus_valid_0 && (beat_cnt == databus_len_0 - 8'd1);

  always @(posedge clk or negedge rst) begin
    if (!rst) beat_cnt <= 8'd0;
    else if (run && !disabled) beat_cnt <= 8'd0;
    else if (databus_valid_0 && databus_ready_0) beat_cnt <= databus_last_0 ? 8'd0 : beat_cnt + 8'd1;
  end

  always @(negedge clk) begin
    if (chk_stall && stalled_prev) begin
      total++;
      assert ({databus_valid_0, databus_addr_0, databus_len_0, databus_wdata_0} ===
              {1'b1, prev_addr, prev_len, prev_wdata})
      else begin
        bad++;
        $error("FAIL stall_hold got v=%b a=%h l=%0d d=%h want v=1 a=%h l=%0d d=%h",
               databus_valid_0, databus_addr_0, databus_len_0, databus_wdata_0,
               prev_addr, prev_len, prev_wdata);
      end
    end
    stalled_prev = databus_valid_0 && !databus_ready_0;
    prev_addr    = databus_addr_0;
    prev_len     = databus_len_0;
    prev_wdata   = databus_wdata_0;
    if (databus_valid_0) valid_cnt++;
    if (databus_valid_0 && databus_ready_0) begin
      if (beat_cnt == 8'd0) begin
        baddr_q.push_back(databus_addr_0);
        blen_q.push_back(databus_len_0);
      end
      data_q.push_back(databus_wdata_0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (stall_left > 0) begin
      databus_ready_0 = 1'b0;
      stall_left--;
    end else begin
      case (mode)
        0:       databus_ready_0 = 1'b1;
        1:       databus_ready_0 = !databus_ready_0;
        2:       databus_ready_0 = 1'b0;
        default: databus_ready_0 = 1'($urandom_range(0, 1));
      endcase
    end
    in0 = $urandom;
    in0_hist[cyc] = in0;
  endtask

  task automatic clear_mon();
    data_q.delete();
    baddr_q.delete();
    blen_q.delete();
    valid_cnt = 0;
  endtask

  task automatic start_op(input logic [31:0] a, input int n, input int len, input int dly,
                          output int rc);
    clear_mon();
    ext_addr = a;
    count    = 32'(n);
    length   = 8'(len);
    delay0   = 32'(dly);
    run      = 1'b1;
    rc       = cyc;
    tick();
    run      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    for (int i = 0; i < lim && done !== 1'b1; i++) tick();
    total++;
    assert (done === 1'b1) else begin
      bad++;
      $error("FAIL %s done got=%b want=1", tag, done);
    end
  endtask

  task automatic wait_valid(input string tag, input int lim);
    for (int i = 0; i < lim && databus_valid_0 !== 1'b1; i++) tick();
    total++;
    assert (databus_valid_0 === 1'b1) else begin
      bad++;
      $error("FAIL %s valid got=%b want=1", tag, databus_valid_0);
    end
  endtask

  // Reference: w words written = the first w samples in capture order, chunked by max(len,1).
  task automatic check_op(input string tag, input logic [31:0] base, input int len, input int dly,
                          input int rc, input int w, input logic ovf);
    int b, rem, k;
    logic [31:0] a, exp_d;
    total++;
    assert (data_q.size() === w) else begin
      bad++;
      $error("FAIL %s words got=%0d want=%0d", tag, data_q.size(), w);
    end
    for (int i = 0; i < w && i < data_q.size(); i++) begin
      exp_d = in0_hist[rc + 1 + dly + i];
      total++;
      assert (data_q[i] === exp_d) else begin
        bad++;
        $error("FAIL %s data[%0d] got=%h want=%h", tag, i, data_q[i], exp_d);
      end
    end
    rem = w;
    a = base;
    k = 0;
    while (rem > 0) begin
      b = (len < 1) ? 1 : len;
      if (b > rem) b = rem;
      total++;
      assert (k < baddr_q.size() && baddr_q[k] === a && blen_q[k] === 8'(b)) else begin
        bad++;
        $error("FAIL %s burst%0d got a=%h l=%0d want a=%h l=%0d", tag, k,
               (k < baddr_q.size()) ? baddr_q[k] : 32'hx, (k < blen_q.size()) ? blen_q[k] : 8'hx, a, b);
      end
      a = a + 32'(b * 4);
      rem -= b;
      k++;
    end
    total++;
    assert (baddr_q.size() === k) else begin
      bad++;
      $error("FAIL %s bursts got=%0d want=%0d", tag, baddr_q.size(), k);
    end
    total++;
    assert (overflow === ovf) else begin
      bad++;
      $error("FAIL %s overflow got=%b want=%b", tag, overflow, ovf);
    end
  endtask

  initial begin
    logic [31:0] ra;
    int rn, rl, rd;
    total = 0; bad = 0; cyc = 0; mode = 0; stall_left = 0; chk_stall = 0; stalled_prev = 0;
    rst = 1'b0; run = 1'b0; running = 1'b0; disabled = 1'b0;
    in0 = '0; ext_addr = '0; count = '0; length = '0; delay0 = '0;
    databus_ready_0 = 1'b1; databus_rdata_0 = 32'hDEAD_BEEF;
    clear_mon();
    repeat (3) tick();

    total++;
    assert ({done, overflow, databus_valid_0} === 3'b100) else begin
      bad++;
      $error("FAIL reset_flags got d/o/v=%b%b%b want=100", done, overflow, databus_valid_0);
    end
    total++;
    assert ({databus_addr_0, databus_len_0} === 40'd0) else begin
      bad++;
      $error("FAIL reset_bus got a=%h l=%0d want 0", databus_addr_0, databus_len_0);
    end
    rst = 1'b1;
    running = 1'b1;

    start_op(32'h1000, 8, 4, 3, r);
    wait_done("basic8", 200);
    check_op("basic8", 32'h1000, 4, 3, r, 8, 1'b0);

    start_op(32'h0, 10, 4, 1, r);
    wait_done("tail10", 200);
    check_op("tail10", 32'h0, 4, 1, r, 10, 1'b0);

    start_op(32'hFFFF_FFF0, 9, 3, 0, r);
    wait_done("wrap", 200);
    check_op("wrap", 32'hFFFF_FFF0, 3, 0, r, 9, 1'b0);

    chk_stall = 1'b1;
    mode = 1;
    start_op(32'h200, 12, 4, 0, r);
    wait_done("toggle", 300);
    check_op("toggle", 32'h200, 4, 0, r, 12, 1'b0);

    mode = 3;
    for (int t = 0; t < 3; t++) begin
      ra = $urandom;
      rn = $urandom_range(1, 16);
      rl = $urandom_range(0, 6);
      rd = $urandom_range(0, 5);
      start_op(ra, rn, rl, rd, r);
      wait_done("rand", 400);
      check_op("rand", ra, rl, rd, r, rn, 1'b0);
    end
    chk_stall = 1'b0;

    mode = 0;
    stall_left = 40;
    start_op(32'h8000, 32, 4, 0, r);
    wait_done("ovf", 400);
    check_op("ovf", 32'h8000, 4, 0, r, 16, 1'b1);

    disabled = 1'b1;
    start_op(32'h9000, 8, 4, 0, r);
    repeat (12) tick();
    total++;
    assert ({done, 32'(valid_cnt)} === {1'b1, 32'd0}) else begin
      bad++;
      $error("FAIL disabled got done=%b valid_cycles=%0d want 1/0", done, valid_cnt);
    end
    disabled = 1'b0;

    start_op(32'hA000, 0, 4, 2, r);
    total++;
    assert (done === 1'b0) else begin
      bad++;
      $error("FAIL zero_busy done got=%b want=0", done);
    end
    wait_done("zero", 50);
    total++;
    assert (valid_cnt === 0) else begin
      bad++;
      $error("FAIL zero_bus valid_cycles got=%0d want=0", valid_cnt);
    end

    mode = 2;
    start_op(32'h3000, 8, 4, 0, r);
    wait_valid("abort_pre", 50);
    total++;
    assert ({databus_addr_0, databus_len_0, databus_wstrb_0} === {32'h3000, 8'd4, 4'hF}) else begin
      bad++;
      $error("FAIL burst_hdr got a=%h l=%0d s=%h want a=3000 l=4 s=f",
             databus_addr_0, databus_len_0, databus_wstrb_0);
    end
    clear_mon();
    mode = 0;
    ext_addr = 32'h4000; count = 32'd6; length = 8'd4; delay0 = 32'd2;
    databus_ready_0 = 1'b1;
    run = 1'b1;
    r = cyc;
    #1;
    total++;
    assert (databus_valid_0 === 1'b0) else begin
      bad++;
      $error("FAIL abort_drop valid got=%b want=0", databus_valid_0);
    end
    tick();
    run = 1'b0;
    wait_done("abort", 200);
    check_op("abort", 32'h4000, 4, 2, r, 6, 1'b0);

    mode = 2;
    start_op(32'h5000, 8, 4, 0, r);
    wait_valid("rst_pre", 50);
    #2;
    rst = 1'b0;
    #1;
    total++;
    assert ({databus_valid_0, done, overflow} === 3'b010) else begin
      bad++;
      $error("FAIL rst_mid got v/d/o=%b%b%b want=010", databus_valid_0, done, overflow);
    end
    mode = 0;
    tick();
    tick();
    rst = 1'b1;
    start_op(32'h6000, 8, 4, 2, r);
    wait_done("post_rst", 200);
    check_op("post_rst", 32'h6000, 4, 2, r, 8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
